epl_read_arb_ctrl: RTL and testbench

- Read-path controller for the EPLFFRAM02 Hamming(7,4) array.
- Arbitrates word-read requests from two requesters: A = host and B = scrubber.
- Sequences each granted read: row select, column-phase select (pAcy2), read strobe to the read mux, capture of the registered 7-bit word.
- Decodes the word with single-error correction and returns 4-bit data plus status to the requester that was granted; one transaction outstanding at a time.

---
 rtl/epl_read_arb_ctrl_if.sv | 60 ++++++
 rtl/epl_read_arb_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_epl_read_arb_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/epl_read_arb_ctrl_if.sv
// rtl/epl_read_arb_ctrl_if.sv - requester, response and array-side bundle for epl_read_arb_ctrl
//
// Purpose: groups every non-clock/reset signal of the EPLFFRAM02 read-path
// controller. The _i/_o suffixes are seen from the controller.
//
// Signals:
//   pReqA_i/pAddrA_i/pRdyA_o        requester A (host) read request channel
//   pReqB_i/pAddrB_i/pRdyB_o        requester B (scrubber) read request channel
//   pRspVldA_o/pRspRdyA_i           response handshake to A
//   pRspVldB_o/pRspRdyB_i           response handshake to B
//   pRspData_o/pRspCorr_o/pRspTo_o  shared response payload and status
//   pRow_o/pRowEn_o/pAcy2_o         row address, row enable, one-hot column phase
//   pRead01_o                       read strobe to the read mux
//   pDo_i/pRead1_i                  registered 7-bit word and its valid from the read mux
//
// Modports: slave = the controller, master = the environment driving it.

interface epl_read_arb_ctrl_if #(
    parameter int ROW_AW = 4
);
    logic              pReqA_i;
    logic [ROW_AW:0]   pAddrA_i;
    logic              pRdyA_o;
    logic              pReqB_i;
    logic [ROW_AW:0]   pAddrB_i;
    logic              pRdyB_o;

    logic              pRspVldA_o;
    logic              pRspRdyA_i;
    logic              pRspVldB_o;
    logic              pRspRdyB_i;
    logic [3:0]        pRspData_o;
    logic              pRspCorr_o;
    logic              pRspTo_o;

    logic [ROW_AW-1:0] pRow_o;
    logic              pRowEn_o;
    logic [1:0]        pAcy2_o;
    logic              pRead01_o;
    logic [6:0]        pDo_i;
    logic              pRead1_i;

    modport slave (
        input  pReqA_i, pAddrA_i, pReqB_i, pAddrB_i,
        input  pRspRdyA_i, pRspRdyB_i,
        input  pDo_i, pRead1_i,
        output pRdyA_o, pRdyB_o,
        output pRspVldA_o, pRspVldB_o, pRspData_o, pRspCorr_o, pRspTo_o,
        output pRow_o, pRowEn_o, pAcy2_o, pRead01_o
    );

    modport master (
        output pReqA_i, pAddrA_i, pReqB_i, pAddrB_i,
        output pRspRdyA_i, pRspRdyB_i,
        output pDo_i, pRead1_i,
        input  pRdyA_o, pRdyB_o,
        input  pRspVldA_o, pRspVldB_o, pRspData_o, pRspCorr_o, pRspTo_o,
        input  pRow_o, pRowEn_o, pAcy2_o, pRead01_o
    );
endinterface

// File: rtl/epl_read_arb_ctrl.sv
// rtl/epl_read_arb_ctrl.sv - two-requester read arbiter and sequencer for the EPLFFRAM02 Hamming(7,4) array
//
// Purpose: accepts word reads from requester A (host) and B (scrubber) with
// round-robin arbitration, drives row select / column phase / read strobe to
// the array, captures the 7-bit word from the read mux, corrects a single-bit
// error and returns 4-bit data with status to the granted requester. One
// transaction is outstanding at a time.
//
// Ports:
//   pClk_i   clock
//   nRst_i   synchronous reset, active-low
//   bus      epl_read_arb_ctrl_if.slave (request, response and array-side signals)
//
// Parameters:
//   ROW_AW     row address width; word address is {row, column phase}
//   ARRAY_LAT  cycles from row enable to valid column data (1..3)
//   TO_CYC     cycles allowed in WAIT for the mux valid before timeout (2..15)

module epl_read_arb_ctrl #(
    parameter int ROW_AW    = 4,
    parameter int ARRAY_LAT = 1,
    parameter int TO_CYC    = 4
) (
    input  logic                  pClk_i,
    input  logic                  nRst_i,
    epl_read_arb_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_STROBE,
        ST_WAIT,
        ST_RESP
    } stateT;

    localparam logic [1:0] LAT_LOAD = 2'(ARRAY_LAT - 1);
    localparam logic [3:0] TO_LAST  = 4'(TO_CYC - 1);

    stateT             state;
    logic              lastB;      // 1 = B was granted most recently
    logic              ownerB;     // owner of the transaction in flight
    logic [1:0]        latCnt;
    logic [3:0]        toCnt;

    logic [ROW_AW-1:0] rowQ;
    logic              rowEnQ;
    logic [1:0]        acy2Q;
    logic              read01Q;
    logic              rspVldAQ;
    logic              rspVldBQ;
    logic [3:0]        rspDataQ;
    logic              rspCorrQ;
    logic              rspToQ;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the one not granted
    // last wins. winB is derived from winA so both can never be high.
    // ------------------------------------------------------------------
    logic            winA;
    logic            winB;
    logic            rdyA;
    logic            rdyB;
    logic [ROW_AW:0] selAddr;

    always_comb begin
        winA    = bus.pReqA_i && (!bus.pReqB_i || lastB);
        winB    = bus.pReqB_i && !winA;
        rdyA    = (state == ST_IDLE) && winA;
        rdyB    = (state == ST_IDLE) && winB;
        selAddr = winB ? bus.pAddrB_i : bus.pAddrA_i;
    end

    assign bus.pRdyA_o = rdyA;
    assign bus.pRdyB_o = rdyB;

    // ------------------------------------------------------------------
    // Hamming(7,4) single-error correction. Codeword position cN sits on
    // pDo_i[N-1]; the syndrome value is the 1-based position in error.
    // ------------------------------------------------------------------
    logic [6:0] cw;
    logic [6:0] fixedCw;
    logic [2:0] syn;
    logic [3:0] decData;
    logic       decCorr;

    always_comb begin
        cw      = bus.pDo_i;
        syn[0]  = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1]  = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2]  = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        fixedCw = cw;
        decCorr = 1'b0;
        if (syn != 3'd0) begin
            fixedCw[syn - 3'd1] = ~cw[syn - 3'd1];
            decCorr             = 1'b1;
        end
        decData = {fixedCw[6], fixedCw[5], fixedCw[4], fixedCw[2]};
    end

    // Response handshake comes only from the owner; the other ready is ignored.
    logic ownerRspRdy;
    assign ownerRspRdy = ownerB ? bus.pRspRdyB_i : bus.pRspRdyA_i;

    // ------------------------------------------------------------------
    // Sequencer with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge pClk_i) begin
        if (!nRst_i) begin
            state    <= ST_IDLE;
            lastB    <= 1'b1;      // A wins the first tie after reset
            ownerB   <= 1'b0;
            latCnt   <= 2'd0;
            toCnt    <= 4'd0;
            rowQ     <= '0;
            rowEnQ   <= 1'b0;
            acy2Q    <= 2'b00;
            read01Q  <= 1'b0;
            rspVldAQ <= 1'b0;
            rspVldBQ <= 1'b0;
            rspDataQ <= 4'd0;
            rspCorrQ <= 1'b0;
            rspToQ   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rdyA || rdyB) begin
                        ownerB <= rdyB;
                        lastB  <= rdyB;
                        // The row/phase outputs double as the address latch.
                        rowQ   <= selAddr[ROW_AW:1];
                        acy2Q  <= selAddr[0] ? 2'b10 : 2'b01;
                        rowEnQ <= 1'b1;
                        latCnt <= LAT_LOAD;
                        state  <= ST_ROW;
                    end
                end

                ST_ROW: begin
                    if (latCnt == 2'd0) begin
                        read01Q <= 1'b1;
                        state   <= ST_STROBE;
                    end else begin
                        latCnt <= latCnt - 2'd1;
                    end
                end

                ST_STROBE: begin
                    read01Q <= 1'b0;
                    toCnt   <= 4'd0;
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.pRead1_i || (toCnt == TO_LAST)) begin
                        // A valid word in the last allowed cycle still wins
                        // over the timeout.
                        rspDataQ <= bus.pRead1_i ? decData : 4'd0;
                        rspCorrQ <= bus.pRead1_i ? decCorr : 1'b0;
                        rspToQ   <= !bus.pRead1_i;
                        rowEnQ   <= 1'b0;
                        acy2Q    <= 2'b00;
                        rspVldAQ <= !ownerB;
                        rspVldBQ <= ownerB;
                        state    <= ST_RESP;
                    end else begin
                        toCnt <= toCnt + 4'd1;
                    end
                end

                ST_RESP: begin
                    if (ownerRspRdy) begin
                        rspVldAQ <= 1'b0;
                        rspVldBQ <= 1'b0;
                        rspDataQ <= 4'd0;
                        rspCorrQ <= 1'b0;
                        rspToQ   <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pRow_o      = rowQ;
    assign bus.pRowEn_o    = rowEnQ;
    assign bus.pAcy2_o     = acy2Q;
    assign bus.pRead01_o   = read01Q;
    assign bus.pRspVldA_o  = rspVldAQ;
    assign bus.pRspVldB_o  = rspVldBQ;
    assign bus.pRspData_o  = rspDataQ;
    assign bus.pRspCorr_o  = rspCorrQ;
    assign bus.pRspTo_o    = rspToQ;

endmodule

// File: tb/tb_epl_read_arb_ctrl.sv
// tb/tb_epl_read_arb_ctrl.sv - directed scoreboard bench for epl_read_arb_ctrl

module tb_epl_read_arb_ctrl;

    typedef struct packed {
        logic       ownerB;
        logic [3:0] data;
        logic       corr;
        logic       to;
    } expT;

    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    epl_read_arb_ctrl_if #(.ROW_AW(4)) bus ();

    epl_read_arb_ctrl #(
        .ROW_AW   (4),
        .ARRAY_LAT(1),
        .TO_CYC   (4)
    ) dut (
        .pClk_i(clk),
        .nRst_i(nRst),
        .bus   (bus)
    );

    int         nVec = 0;
    int         nMis = 0;
    expT        expQ[$];
    logic [6:0] muxWord = 7'h00;
    bit         muxDead = 1'b0;

    // Read mux model: answers one cycle after the strobe cycle.
    initial begin
        bit strobeSeen;
        strobeSeen   = 1'b0;
        bus.pRead1_i = 1'b0;
        bus.pDo_i    = 7'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.pRead1_i = strobeSeen && !muxDead;
            bus.pDo_i    = muxWord;
            strobeSeen   = bus.pRead01_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitAccept(input bit expB, input logic [3:0] d, input bit c, input bit t);
        bit  got;
        expT e;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            #1;
            if (bus.pRdyA_o || bus.pRdyB_o) begin
                got = 1'b1;
                chk("rdy_exclusive", 32'(bus.pRdyA_o & bus.pRdyB_o), 32'd0);
                chk("grant_owner", 32'(bus.pRdyB_o), 32'(expB));
                e.ownerB = expB;
                e.data   = d;
                e.corr   = c;
                e.to     = t;
                expQ.push_back(e);
            end
            step();
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitRsp(input int hold, input bit otherRdy);
        bit  got;
        expT e;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (bus.pRspVldA_o || bus.pRspVldB_o) got = 1'b1;
            else step();
        end
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        if (expQ.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        chk("rsp_vldA", 32'(bus.pRspVldA_o), 32'(!e.ownerB));
        chk("rsp_vldB", 32'(bus.pRspVldB_o), 32'(e.ownerB));
        chk("rsp_data", 32'(bus.pRspData_o), 32'(e.data));
        chk("rsp_corr", 32'(bus.pRspCorr_o), 32'(e.corr));
        chk("rsp_to", 32'(bus.pRspTo_o), 32'(e.to));
        chk("rsp_rowen", 32'(bus.pRowEn_o), 32'd0);
        chk("rsp_acy2", 32'(bus.pAcy2_o), 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (e.ownerB) bus.pRspRdyA_i = otherRdy;
            else          bus.pRspRdyB_i = otherRdy;
            step();
            chk("hold_vld", 32'(e.ownerB ? bus.pRspVldB_o : bus.pRspVldA_o), 32'd1);
            chk("hold_data", 32'(bus.pRspData_o), 32'(e.data));
            chk("hold_flags", 32'({bus.pRspCorr_o, bus.pRspTo_o}), 32'({e.corr, e.to}));
        end
        bus.pRspRdyA_i = !e.ownerB;
        bus.pRspRdyB_i = e.ownerB;
        step();
        bus.pRspRdyA_i = 1'b0;
        bus.pRspRdyB_i = 1'b0;
        chk("rsp_done", 32'(bus.pRspVldA_o | bus.pRspVldB_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        nRst           = 1'b0;
        bus.pReqA_i    = 1'b0;
        bus.pReqB_i    = 1'b0;
        bus.pAddrA_i   = '0;
        bus.pAddrB_i   = '0;
        bus.pRspRdyA_i = 1'b0;
        bus.pRspRdyB_i = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_rowen", 32'(bus.pRowEn_o), 32'd0);
        chk("rst_acy2", 32'(bus.pAcy2_o), 32'd0);
        chk("rst_read01", 32'(bus.pRead01_o), 32'd0);
        chk("rst_vld", 32'({bus.pRspVldA_o, bus.pRspVldB_o}), 32'd0);
        chk("rst_rdy", 32'({bus.pRdyA_o, bus.pRdyB_o}), 32'd0);
        nRst = 1'b1;
        step();

        // A reads 5'b00011, mux returns 7'h55 -> data B, exact latency
        muxWord      = 7'h55;
        bus.pReqA_i  = 1'b1;
        bus.pAddrA_i = 5'b00011;
        waitAccept(1'b0, 4'hB, 1'b0, 1'b0);
        bus.pReqA_i  = 1'b0;
        chk("t1_row_en", 32'(bus.pRowEn_o), 32'd1);
        chk("t1_row", 32'(bus.pRow_o), 32'd1);
        chk("t1_acy2", 32'(bus.pAcy2_o), 32'b10);
        chk("t1_rd_t1", 32'(bus.pRead01_o), 32'd0);
        step();
        chk("t1_rd_t2", 32'(bus.pRead01_o), 32'd1);
        chk("t1_acy2_strobe", 32'(bus.pAcy2_o), 32'b10);
        step();
        chk("t1_rd_t3", 32'(bus.pRead01_o), 32'd0);
        chk("t1_rowen_wait", 32'(bus.pRowEn_o), 32'd1);
        chk("t1_vld_t3", 32'(bus.pRspVldA_o), 32'd0);
        step();
        chk("t1_vld_t4", 32'(bus.pRspVldA_o), 32'd1);
        waitRsp(0, 1'b0);

        // B reads 5'b00100, mux returns 7'h45 (c5 flipped)
        muxWord      = 7'h45;
        bus.pReqB_i  = 1'b1;
        bus.pAddrB_i = 5'b00100;
        waitAccept(1'b1, 4'hB, 1'b1, 1'b0);
        bus.pReqB_i  = 1'b0;
        chk("t2_acy2", 32'(bus.pAcy2_o), 32'b01);
        chk("t2_row", 32'(bus.pRow_o), 32'd2);
        waitRsp(0, 1'b0);

        // Both request continuously: grants alternate A, B, A, B
        muxWord      = 7'h00;
        bus.pReqA_i  = 1'b1;
        bus.pReqB_i  = 1'b1;
        bus.pAddrA_i = 5'b01010;
        bus.pAddrB_i = 5'b10101;
        for (int k = 0; k < 4; k++) begin
            waitAccept(k[0], 4'h0, 1'b0, 1'b0);
            waitRsp(0, 1'b0);
        end
        bus.pReqA_i = 1'b0;
        bus.pReqB_i = 1'b0;
        step();

        // Mux never answers: 4 WAIT cycles then timeout
        muxDead      = 1'b1;
        bus.pReqA_i  = 1'b1;
        bus.pAddrA_i = 5'b00000;
        waitAccept(1'b0, 4'h0, 1'b0, 1'b1);
        bus.pReqA_i  = 1'b0;
        repeat (5) step();
        chk("t4_vld_before_to", 32'(bus.pRspVldA_o), 32'd0);
        step();
        chk("t4_vld_at_to", 32'(bus.pRspVldA_o), 32'd1);
        waitRsp(0, 1'b0);
        muxDead      = 1'b0;
        muxWord      = 7'h55;
        bus.pReqA_i  = 1'b1;
        bus.pAddrA_i = 5'b00010;
        waitAccept(1'b0, 4'hB, 1'b0, 1'b0);
        bus.pReqA_i  = 1'b0;
        waitRsp(0, 1'b0);

        // A response held 3 cycles; B stalls, then granted right after
        muxWord      = 7'h7F;
        bus.pReqA_i  = 1'b1;
        bus.pAddrA_i = 5'b00110;
        waitAccept(1'b0, 4'hF, 1'b0, 1'b0);
        bus.pReqA_i  = 1'b0;
        bus.pReqB_i  = 1'b1;
        bus.pAddrB_i = 5'b01001;
        #1;
        chk("t5_b_stall", 32'(bus.pRdyB_o), 32'd0);
        waitRsp(3, 1'b1);
        #1;
        chk("t5_b_grant_after_hs", 32'(bus.pRdyB_o), 32'd1);
        waitAccept(1'b1, 4'hF, 1'b0, 1'b0);
        bus.pReqB_i = 1'b0;
        chk("t5_b_row", 32'(bus.pRow_o), 32'd4);
        waitRsp(0, 1'b0);

        // Reset during WAIT aborts the transaction
        muxDead      = 1'b1;
        bus.pReqA_i  = 1'b1;
        bus.pAddrA_i = 5'b00101;
        waitAccept(1'b0, 4'h0, 1'b0, 1'b1);
        bus.pReqA_i  = 1'b0;
        repeat (2) step();
        nRst = 1'b0;
        step();
        chk("t6_rst_rowen", 32'(bus.pRowEn_o), 32'd0);
        chk("t6_rst_row", 32'(bus.pRow_o), 32'd0);
        chk("t6_rst_acy2", 32'(bus.pAcy2_o), 32'd0);
        chk("t6_rst_read01", 32'(bus.pRead01_o), 32'd0);
        chk("t6_rst_vld", 32'({bus.pRspVldA_o, bus.pRspVldB_o}), 32'd0);
        chk("t6_rst_rsp", 32'({bus.pRspData_o, bus.pRspCorr_o, bus.pRspTo_o}), 32'd0);
        nRst    = 1'b1;
        muxDead = 1'b0;
        expQ.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_no_rsp", 32'({bus.pRspVldA_o, bus.pRspVldB_o}), 32'd0);
        end
        muxWord      = 7'h55;
        bus.pReqA_i  = 1'b1;
        bus.pReqB_i  = 1'b1;
        bus.pAddrA_i = 5'b00001;
        bus.pAddrB_i = 5'b00010;
        waitAccept(1'b0, 4'hB, 1'b0, 1'b0);
        bus.pReqA_i  = 1'b0;
        waitRsp(0, 1'b0);
        waitAccept(1'b1, 4'hB, 1'b0, 1'b0);
        bus.pReqB_i  = 1'b0;
        waitRsp(0, 1'b0);
        chk("t6_queue_empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
